afu_job_ctl: RTL and testbench

Parametrised PSL job-control engine for the AFU top level. It decodes the control interface (`ha_jval`/`ha_jcom`), sequences the job through reset, start, run and done, and generates `ah_jrunning`, `ah_jdone`, `ah_jcack` and `ah_jerror`. It also adds a configurable done latency, command parity checking, a run watchdog and LLCMD acknowledge. It sits between the PSL control interface and the AFU work engine, and replaces the inline job logic plus the fixed `ah_jdone` shift register.

---
 rtl/afu_job_ctl_if.sv | 39 +++
 rtl/afu_job_ctl.sv | 159 +++++++++++++++
 tb/tb_afu_job_ctl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afu_job_ctl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// afu_job_ctl_if : PSL job-control and work-engine signal bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface afu_job_ctl_if;
  logic        ha_jval;
  logic [0:7]  ha_jcom;
  logic        ha_jcompar;
  logic [0:63] ha_jea;
  logic        ha_jeapar;
  logic        work_done;
  logic        work_err;
  logic [0:7]  work_err_code;
  logic        job_start;
  logic        job_reset;
  logic [0:63] job_ea;
  logic        ah_jrunning;
  logic        ah_jdone;
  logic        ah_jcack;
  logic [0:63] ah_jerror;
  logic        ah_jyield;

  // master = PSL host plus work engine; slave = the job controller
  modport master (
    output ha_jval, ha_jcom, ha_jcompar, ha_jea, ha_jeapar,
    output work_done, work_err, work_err_code,
    input  job_start, job_reset, job_ea,
    input  ah_jrunning, ah_jdone, ah_jcack, ah_jerror, ah_jyield
  );

  modport slave (
    input  ha_jval, ha_jcom, ha_jcompar, ha_jea, ha_jeapar,
    input  work_done, work_err, work_err_code,
    output job_start, job_reset, job_ea,
    output ah_jrunning, ah_jdone, ah_jcack, ah_jerror, ah_jyield
  );
endinterface
`default_nettype wire

// File: rtl/afu_job_ctl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// afu_job_ctl : PSL job sequencing, done latency, parity check, run watchdog
// Rev 1.0
// ----------------------------------------------------------------------------
module afu_job_ctl #(
  parameter int unsigned DONE_LATENCY   = 1,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd0,
  parameter bit          CHECK_PARITY   = 1'b1
) (
  input  wire logic        ha_pclock,
  input  wire logic        reset,
  afu_job_ctl_if.slave     bus
);

  localparam logic [0:7] OP_RESET     = 8'h80;
  localparam logic [0:7] OP_START     = 8'h90;
  localparam logic [0:7] OP_LLCMD     = 8'h45;
  localparam logic [0:7] CAT_TIMEOUT  = 8'h01;
  localparam logic [0:7] CAT_REENTRY  = 8'h02;
  localparam logic [0:7] CAT_PARITY   = 8'h03;
  localparam logic [0:7] CAT_ENGINE   = 8'h04;

  typedef enum logic {S_IDLE = 1'b0, S_RUNNING = 1'b1} state_t;

  state_t      r_state, w_state_next;
  logic        r_job_start, r_job_reset, r_jcack, r_done;
  logic [0:63] r_job_ea, r_jerror;
  logic [31:0] r_wdog;

  logic        w_running, w_par_err, w_timeout;
  logic        w_cmd_reset, w_cmd_start, w_cmd_llcmd;
  logic        w_start, w_reset, w_done, w_ack, w_err_load;
  logic [0:63] w_err_val;

  assign w_running   = (r_state == S_RUNNING);
  assign w_cmd_reset = bus.ha_jval && (bus.ha_jcom == OP_RESET);
  assign w_cmd_start = bus.ha_jval && (bus.ha_jcom == OP_START);
  assign w_cmd_llcmd = bus.ha_jval && (bus.ha_jcom == OP_LLCMD);

  // Odd parity: data plus parity bit must XOR to 1
  assign w_par_err = CHECK_PARITY && bus.ha_jval &&
                     (!(^{bus.ha_jcom, bus.ha_jcompar}) || !(^{bus.ha_jea, bus.ha_jeapar}));

  // Counter reads k-1 in the k-th running cycle, so N-1 marks cycle start+N
  assign w_timeout = w_running && (TIMEOUT_CYCLES != 32'd0) &&
                     (r_wdog >= (TIMEOUT_CYCLES - 32'd1));

  assign w_ack = w_running && w_cmd_llcmd && !w_par_err;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_reset      = 1'b0;
    w_done       = 1'b0;
    w_err_load   = 1'b0;
    w_err_val    = '0;
    if (w_par_err) begin
      w_reset      = 1'b1;
      w_done       = 1'b1;
      w_err_load   = 1'b1;
      w_err_val    = {CAT_PARITY, 56'h0};
      w_state_next = S_IDLE;
    end else if (w_cmd_reset) begin
      w_reset      = 1'b1;
      w_done       = 1'b1;
      w_err_load   = 1'b1;
      w_state_next = S_IDLE;
    end else if (w_running && bus.work_done) begin
      w_done       = 1'b1;
      w_err_load   = 1'b1;
      w_state_next = S_IDLE;
      if (bus.work_err) begin
        w_err_val = {CAT_ENGINE, 48'h0, bus.work_err_code};
      end
    end else if (w_running && w_cmd_start) begin
      w_done       = 1'b1;
      w_err_load   = 1'b1;
      w_err_val    = {CAT_REENTRY, 56'h0};
      w_state_next = S_IDLE;
    end else if (w_timeout) begin
      w_done       = 1'b1;
      w_err_load   = 1'b1;
      w_err_val    = {CAT_TIMEOUT, 56'h0};
      w_state_next = S_IDLE;
    end else if (!w_running && w_cmd_start) begin
      w_start      = 1'b1;
      w_err_load   = 1'b1;
      w_state_next = S_RUNNING;
    end
  end

  always_ff @(posedge ha_pclock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge ha_pclock) begin
    if (reset) begin
      r_job_start <= 1'b0;
      r_job_reset <= 1'b0;
      r_jcack     <= 1'b0;
      r_done      <= 1'b0;
      r_job_ea    <= '0;
      r_jerror    <= '0;
      r_wdog      <= '0;
    end else begin
      r_job_start <= w_start;
      r_job_reset <= w_reset;
      r_jcack     <= w_ack;
      r_done      <= w_done;
      if (w_start) begin
        r_job_ea <= bus.ha_jea;
      end
      if (w_err_load) begin
        r_jerror <= w_err_val;
      end
      if (w_running && (w_state_next == S_RUNNING)) begin
        if (r_wdog != 32'hFFFF_FFFF) begin
          r_wdog <= r_wdog + 32'd1;
        end
      end else begin
        r_wdog <= '0;
      end
    end
  end

  generate
    if (DONE_LATENCY == 0) begin : g_done_direct
      assign bus.ah_jdone = r_done;
    end else begin : g_done_pipe
      logic [DONE_LATENCY-1:0] r_pipe;
      always_ff @(posedge ha_pclock) begin
        if (reset) begin
          r_pipe <= '0;
        end else begin
          r_pipe[0] <= r_done;
          for (int i = 1; i < int'(DONE_LATENCY); i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end
      assign bus.ah_jdone = r_pipe[DONE_LATENCY-1];
    end
  endgenerate

  assign bus.job_start   = r_job_start;
  assign bus.job_reset   = r_job_reset;
  assign bus.job_ea      = r_job_ea;
  assign bus.ah_jrunning = w_running;
  assign bus.ah_jcack    = r_jcack;
  assign bus.ah_jerror   = r_jerror;
  assign bus.ah_jyield   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_afu_job_ctl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_afu_job_ctl : scoreboard bench for afu_job_ctl (two parameter sets)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_afu_job_ctl;

  localparam int K_START = 0;
  localparam int K_RESET = 1;
  localparam int K_ACK   = 2;
  localparam int K_DONE  = 3;
  localparam int K_RUN   = 4;

  typedef struct {
    int          dut;
    int          kind;
    int          cyc;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic prev_run_a = 1'b0;
  logic prev_run_b = 1'b0;
  exp_t q[$];
  int   t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  afu_job_ctl_if ia ();
  afu_job_ctl_if ib ();

  // A: latency 1, watchdog 8, parity on.  B: latency 2, no watchdog, parity off.
  afu_job_ctl #(.DONE_LATENCY(1), .TIMEOUT_CYCLES(32'd8), .CHECK_PARITY(1'b1)) dut_a (
    .ha_pclock (clk),
    .reset     (reset),
    .bus       (ia)
  );

  afu_job_ctl #(.DONE_LATENCY(2), .TIMEOUT_CYCLES(32'd0), .CHECK_PARITY(1'b0)) dut_b (
    .ha_pclock (clk),
    .reset     (reset),
    .bus       (ib)
  );

  function automatic string kname(input int k);
    case (k)
      K_START: return "job_start";
      K_RESET: return "job_reset";
      K_ACK:   return "ah_jcack";
      K_DONE:  return "ah_jdone";
      default: return "ah_jrunning";
    endcase
  endfunction

  task automatic expect_evt(input int d, input int k, input int c, input logic [63:0] v);
    exp_t e;
    e.dut = d; e.kind = k; e.cyc = c; e.data = v;
    q.push_back(e);
  endtask

  task automatic match_evt(input int d, input int k, input logic [63:0] act);
    int idx;
    idx = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].dut == d && q[i].kind == k) begin
        idx = i;
        break;
      end
    end
    n_checks++;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL %s dut%0d: unexpected event at cycle %0d value %h", kname(k), d, cyc, act);
    end else begin
      if (q[idx].cyc != cyc || q[idx].data !== act) begin
        n_fail++;
        $display("FAIL %s dut%0d: got cycle %0d value %h, expected cycle %0d value %h",
                 kname(k), d, cyc, act, q[idx].cyc, q[idx].data);
      end
      q.delete(idx);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ia.job_start) match_evt(0, K_START, ia.job_ea);
      if (ia.job_reset) match_evt(0, K_RESET, 64'h0);
      if (ia.ah_jcack)  match_evt(0, K_ACK, 64'h0);
      if (ia.ah_jdone)  match_evt(0, K_DONE, ia.ah_jerror);
      if (ia.ah_jrunning !== prev_run_a) begin
        match_evt(0, K_RUN, {63'h0, ia.ah_jrunning});
        prev_run_a = ia.ah_jrunning;
      end
      if (ib.job_start) match_evt(1, K_START, ib.job_ea);
      if (ib.job_reset) match_evt(1, K_RESET, 64'h0);
      if (ib.ah_jcack)  match_evt(1, K_ACK, 64'h0);
      if (ib.ah_jdone)  match_evt(1, K_DONE, ib.ah_jerror);
      if (ib.ah_jrunning !== prev_run_b) begin
        match_evt(1, K_RUN, {63'h0, ib.ah_jrunning});
        prev_run_b = ib.ah_jrunning;
      end
    end
  end

  task automatic clear_pulses();
    ia.ha_jval = 1'b0; ia.work_done = 1'b0; ia.work_err = 1'b0; ia.work_err_code = 8'h0;
    ib.ha_jval = 1'b0; ib.work_done = 1'b0; ib.work_err = 1'b0; ib.work_err_code = 8'h0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      clear_pulses();
    end
  endtask

  task automatic cmd(input int d, input logic [7:0] op, input logic [63:0] ea,
                     input bit bad_cpar, input bit bad_epar);
    if (d == 0) begin
      ia.ha_jval = 1'b1; ia.ha_jcom = op; ia.ha_jcompar = ~(^op) ^ bad_cpar;
      ia.ha_jea = ea; ia.ha_jeapar = ~(^ea) ^ bad_epar;
    end else begin
      ib.ha_jval = 1'b1; ib.ha_jcom = op; ib.ha_jcompar = ~(^op) ^ bad_cpar;
      ib.ha_jea = ea; ib.ha_jeapar = ~(^ea) ^ bad_epar;
    end
  endtask

  task automatic wdone(input int d, input bit err, input logic [7:0] code);
    if (d == 0) begin
      ia.work_done = 1'b1; ia.work_err = err; ia.work_err_code = code;
    end else begin
      ib.work_done = 1'b1; ib.work_err = err; ib.work_err_code = code;
    end
  endtask

  initial begin
    clear_pulses();
    ia.ha_jcom = 8'h0; ia.ha_jcompar = 1'b1; ia.ha_jea = '0; ia.ha_jeapar = 1'b1;
    ib.ha_jcom = 8'h0; ib.ha_jcompar = 1'b1; ib.ha_jea = '0; ib.ha_jeapar = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    // Reset state
    chk("rst_a_running", {63'h0, ia.ah_jrunning}, 64'h0);
    chk("rst_a_jdone",   {63'h0, ia.ah_jdone},    64'h0);
    chk("rst_a_jcack",   {63'h0, ia.ah_jcack},    64'h0);
    chk("rst_a_start",   {63'h0, ia.job_start},   64'h0);
    chk("rst_a_reset",   {63'h0, ia.job_reset},   64'h0);
    chk("rst_a_jerror",  ia.ah_jerror,            64'h0);
    chk("rst_a_job_ea",  ia.job_ea,               64'h0);
    chk("rst_a_jyield",  {63'h0, ia.ah_jyield},   64'h0);
    chk("rst_b_running", {63'h0, ib.ah_jrunning}, 64'h0);
    chk("rst_b_jerror",  ib.ah_jerror,            64'h0);
    mon_en = 1'b1;
    tick(2);

    // Reset command from IDLE
    t0 = cyc;
    cmd(0, 8'h80, 64'h0, 1'b0, 1'b0);
    expect_evt(0, K_RESET, t0 + 1, 64'h0);
    expect_evt(0, K_DONE,  t0 + 2, 64'h0);
    tick(5);

    // Start/complete, then back-to-back start the cycle running falls
    t0 = cyc;
    cmd(0, 8'h90, 64'h1000, 1'b0, 1'b0);
    expect_evt(0, K_START, t0 + 1, 64'h1000);
    expect_evt(0, K_RUN,   t0 + 1, 64'h1);
    tick(5);
    wdone(0, 1'b0, 8'h0);
    expect_evt(0, K_RUN,  t0 + 6, 64'h0);
    expect_evt(0, K_DONE, t0 + 7, 64'h0);
    tick(1);
    cmd(0, 8'h90, 64'h2000, 1'b0, 1'b0);
    expect_evt(0, K_START, t0 + 7, 64'h2000);
    expect_evt(0, K_RUN,   t0 + 7, 64'h1);
    tick(2);
    wdone(0, 1'b0, 8'h0);
    expect_evt(0, K_RUN,  t0 + 9,  64'h0);
    expect_evt(0, K_DONE, t0 + 10, 64'h0);
    tick(1);
    chk("b2b_job_ea", ia.job_ea, 64'h2000);
    tick(4);

    // LLCMD, then LLCMD coinciding with failed work_done
    t0 = cyc;
    cmd(0, 8'h90, 64'hDEAD_BEEF_0000_0040, 1'b0, 1'b0);
    expect_evt(0, K_START, t0 + 1, 64'hDEAD_BEEF_0000_0040);
    expect_evt(0, K_RUN,   t0 + 1, 64'h1);
    tick(2);
    cmd(0, 8'h45, 64'h0, 1'b0, 1'b0);
    expect_evt(0, K_ACK, t0 + 3, 64'h0);
    tick(2);
    cmd(0, 8'h45, 64'h0, 1'b0, 1'b0);
    wdone(0, 1'b1, 8'h2A);
    expect_evt(0, K_ACK,  t0 + 5, 64'h0);
    expect_evt(0, K_RUN,  t0 + 5, 64'h0);
    expect_evt(0, K_DONE, t0 + 6, 64'h0400_0000_0000_002A);
    tick(5);

    // Ignored in IDLE: LLCMD, unknown opcode, stray work_done; error is held
    cmd(0, 8'h45, 64'h0, 1'b0, 1'b0);
    tick(1);
    cmd(0, 8'h12, 64'h0, 1'b0, 1'b0);
    tick(1);
    wdone(0, 1'b1, 8'h33);
    tick(3);
    chk("idle_jerror_held", ia.ah_jerror, 64'h0400_0000_0000_002A);

    // Watchdog: start at T, timeout event at T+8
    t0 = cyc;
    cmd(0, 8'h90, 64'h3000, 1'b0, 1'b0);
    expect_evt(0, K_START, t0 + 1,  64'h3000);
    expect_evt(0, K_RUN,   t0 + 1,  64'h1);
    expect_evt(0, K_RUN,   t0 + 9,  64'h0);
    expect_evt(0, K_DONE,  t0 + 10, 64'h0100_0000_0000_0000);
    tick(13);

    // Bad command parity on a start, then bad address parity on an LLCMD
    t0 = cyc;
    cmd(0, 8'h90, 64'h4000, 1'b1, 1'b0);
    expect_evt(0, K_RESET, t0 + 1, 64'h0);
    expect_evt(0, K_DONE,  t0 + 2, 64'h0300_0000_0000_0000);
    tick(4);
    chk("par_job_ea", ia.job_ea, 64'h3000);
    t0 = cyc;
    cmd(0, 8'h45, 64'h0F0F, 1'b0, 1'b1);
    expect_evt(0, K_RESET, t0 + 1, 64'h0);
    expect_evt(0, K_DONE,  t0 + 2, 64'h0300_0000_0000_0000);
    tick(4);

    // Parity disabled: bad parity still starts normally; latency 2
    t0 = cyc;
    cmd(1, 8'h90, 64'h5000, 1'b1, 1'b1);
    expect_evt(1, K_START, t0 + 1, 64'h5000);
    expect_evt(1, K_RUN,   t0 + 1, 64'h1);
    tick(3);
    wdone(1, 1'b0, 8'h0);
    expect_evt(1, K_RUN,  t0 + 4, 64'h0);
    expect_evt(1, K_DONE, t0 + 6, 64'h0);
    tick(6);

    // Start while RUNNING
    t0 = cyc;
    cmd(0, 8'h90, 64'h6000, 1'b0, 1'b0);
    expect_evt(0, K_START, t0 + 1, 64'h6000);
    expect_evt(0, K_RUN,   t0 + 1, 64'h1);
    tick(2);
    cmd(0, 8'h90, 64'h7000, 1'b0, 1'b0);
    expect_evt(0, K_RUN,  t0 + 3, 64'h0);
    expect_evt(0, K_DONE, t0 + 4, 64'h0200_0000_0000_0000);
    tick(4);
    chk("rerun_job_ea", ia.job_ea, 64'h6000);

    // Reset command and failed work_done together: reset wins
    t0 = cyc;
    cmd(0, 8'h90, 64'h8000, 1'b0, 1'b0);
    expect_evt(0, K_START, t0 + 1, 64'h8000);
    expect_evt(0, K_RUN,   t0 + 1, 64'h1);
    tick(2);
    cmd(0, 8'h80, 64'h0, 1'b0, 1'b0);
    wdone(0, 1'b1, 8'h55);
    expect_evt(0, K_RESET, t0 + 3, 64'h0);
    expect_evt(0, K_RUN,   t0 + 3, 64'h0);
    expect_evt(0, K_DONE,  t0 + 4, 64'h0);
    tick(5);

    // Reset pin one cycle after work_done drops the in-flight done
    t0 = cyc;
    cmd(0, 8'h90, 64'h9000, 1'b0, 1'b0);
    expect_evt(0, K_START, t0 + 1, 64'h9000);
    expect_evt(0, K_RUN,   t0 + 1, 64'h1);
    tick(2);
    wdone(0, 1'b0, 8'h0);
    expect_evt(0, K_RUN, t0 + 3, 64'h0);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("pin_jdone",   {63'h0, ia.ah_jdone},    64'h0);
    chk("pin_running", {63'h0, ia.ah_jrunning}, 64'h0);
    chk("pin_jerror",  ia.ah_jerror,            64'h0);
    chk("pin_job_ea",  ia.job_ea,               64'h0);
    tick(5);

    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      foreach (q[i]) begin
        $display("FAIL %s dut%0d: expected at cycle %0d value %h, never seen",
                 kname(q[i].kind), q[i].dut, q[i].cyc, q[i].data);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
